toggle_req_gen: RTL and testbench

//  Upstream stage of the sync-reset T flip-flop. Takes a raw, bouncy, asynchronous

---
 rtl/toggle_req_gen.sv | 117 +++++++++++
 tb/tb_toggle_req_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_req_gen.sv
// Debounced button-to-toggle pulse generator with reset-release synchronizer.
// Emits one registered pulse per accepted press and counts accepted presses.
module toggle_req_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_in,
    output logic       reset_sync_n,
    output logic       toggle,
    output logic [7:0] press_count,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] rst_chain;
    logic [SYNC_STAGES-1:0] btn_chain;
    logic                   btn_s;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             toggle_next;
    logic             press_inc;

    // Reset asserts asynchronously and releases only after the chain fills with ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_chain <= '0;
            btn_chain <= '0;
        end else begin
            rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
            btn_chain <= {btn_chain[SYNC_STAGES-2:0], button_in};
        end
    end

    assign reset_sync_n = rst_chain[SYNC_STAGES-1];
    assign btn_s        = btn_chain[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            toggle      <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            toggle      <= toggle_next;
            press_count <= press_count + 8'(press_inc);
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        toggle_next = 1'b0;
        press_inc   = 1'b0;
        if (!reset_sync_n) begin
            // Held in IDLE until the synchronized reset has released.
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state_next = PRESS_DB;
                        cnt_next   = '0;
                    end
                end
                PRESS_DB: begin
                    if (!btn_s) begin
                        state_next = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_next  = PRESSED;
                        toggle_next = 1'b1;
                        press_inc   = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state_next = RELEASE_DB;
                        cnt_next   = '0;
                    end
                end
                RELEASE_DB: begin
                    // A bounce back high returns to PRESSED without a new pulse.
                    if (btn_s) begin
                        state_next = PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_toggle_req_gen.sv
// Randomized and directed bench for toggle_req_gen against a run-length reference model.
// The model accepts a level once btn_s has held it for DEBOUNCE_CYCLES+1 edges.
module tb_toggle_req_gen;

    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       button_in = 1'b0;
    logic       reset_sync_n;
    logic       toggle;
    logic [7:0] press_count;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       m_rs;
    int         m_rel;
    logic       m_deb;
    int         m_run;
    logic       m_last;
    logic       m_tog;
    logic [7:0] m_cnt;
    logic [1:0] m_state;
    logic       hq[$];

    toggle_req_gen #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button_in   (button_in),
        .reset_sync_n(reset_sync_n),
        .toggle      (toggle),
        .press_count (press_count),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        hq.delete();
        for (int i = 0; i < SYNC; i++) hq.push_back(1'b0);
        m_rel = 0; m_rs = 0; m_deb = 0; m_run = 0; m_last = 0;
        m_tog = 0; m_cnt = 8'd0; m_state = 2'd0;
    endtask

    task automatic m_edge(input logic b);
        logic pre_rs, bs;
        pre_rs = m_rs;
        bs = hq.pop_front();
        hq.push_back(b);
        m_rel++;
        m_rs  = (m_rel >= SYNC);
        m_tog = 1'b0;
        if (!pre_rs) begin
            m_deb = 0; m_run = 0; m_state = 2'd0;
        end else begin
            if (m_run == 0 || bs != m_last) begin
                m_run = 1; m_last = bs;
            end else begin
                m_run++;
            end
            if (!m_deb && bs && m_run == DB + 1) begin
                m_deb = 1; m_tog = 1; m_cnt++;
            end else if (m_deb && !bs && m_run == DB + 1) begin
                m_deb = 0;
            end
            m_state = !m_deb ? (bs ? 2'd1 : 2'd0) : (bs ? 2'd2 : 2'd3);
        end
    endtask

    task automatic cycle(input logic b);
        button_in = b;
        @(posedge clk);
        if (reset) m_edge(b);
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        repeat (3) cycle(1'b0);
        n_checks++;
        if ({reset_sync_n, toggle, press_count, state_o} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rs=%b tog=%b cnt=%0d st=%0d required all zero",
                     reset_sync_n, toggle, press_count, state_o);
        end
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0);
            n_checks++;
            if (reset_sync_n !== (i >= SYNC)) begin
                n_fail++;
                $display("FAIL reset_release_edge%0d: got rs=%b required %b", i, reset_sync_n, i >= SYNC);
            end
        end
        reset = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (reset_sync_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_assert: got rs=%b required 0", reset_sync_n);
        end
        cycle(1'b0);
        reset = 1'b1;
        repeat (SYNC) cycle(1'b0);
        n_checks++;
        if (reset_sync_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rerelease: got rs=%b required 1", reset_sync_n);
        end
    endtask

    task automatic test_press_bounce();
        logic seq[15];
        int   pulses = 0;
        seq = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        foreach (seq[i]) begin
            cycle(seq[i]);
            if (toggle === 1'b1) pulses++;
            n_checks++;
            if ({reset_sync_n, toggle, press_count, state_o} !== {m_rs, m_tog, m_cnt, m_state}) begin
                n_fail++;
                $display("FAIL press_bounce_cyc%0d: got %b/%b/%0d/%0d required %b/%b/%0d/%0d", i,
                         reset_sync_n, toggle, press_count, state_o, m_rs, m_tog, m_cnt, m_state);
            end
        end
        n_checks++;
        if (pulses != 0 || press_count !== 8'd0 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL press_bounce_end: got pulses=%0d cnt=%0d st=%0d required 0/0/0",
                     pulses, press_count, state_o);
        end
    endtask

    task automatic test_clean_press();
        int first = 0;
        int pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle(i <= 20);
            if (toggle === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
            n_checks++;
            if ({reset_sync_n, toggle, press_count, state_o} !== {m_rs, m_tog, m_cnt, m_state}) begin
                n_fail++;
                $display("FAIL clean_press_cyc%0d: got %b/%b/%0d/%0d required %b/%b/%0d/%0d", i,
                         reset_sync_n, toggle, press_count, state_o, m_rs, m_tog, m_cnt, m_state);
            end
        end
        n_checks++;
        if (first != SYNC + DB + 1) begin
            n_fail++;
            $display("FAIL clean_press_latency: got edge %0d required %0d", first, SYNC + DB + 1);
        end
        n_checks++;
        if (pulses != 1 || press_count !== 8'd1 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL clean_press_end: got pulses=%0d cnt=%0d st=%0d required 1/1/0",
                     pulses, press_count, state_o);
        end
    endtask

    task automatic test_release_bounce();
        logic seq[25];
        int   pulses = 0;
        int   saw_rel = 0;
        seq = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1,
                1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        foreach (seq[i]) begin
            cycle(seq[i]);
            if (i >= 10 && toggle === 1'b1) pulses++;
            if (state_o === 2'd3) saw_rel++;
            n_checks++;
            if ({reset_sync_n, toggle, press_count, state_o} !== {m_rs, m_tog, m_cnt, m_state}) begin
                n_fail++;
                $display("FAIL release_bounce_cyc%0d: got %b/%b/%0d/%0d required %b/%b/%0d/%0d", i,
                         reset_sync_n, toggle, press_count, state_o, m_rs, m_tog, m_cnt, m_state);
            end
        end
        n_checks++;
        if (pulses != 0 || saw_rel == 0 || state_o !== 2'd2 || press_count !== 8'd2) begin
            n_fail++;
            $display("FAIL release_bounce_end: got pulses=%0d rel_seen=%0d st=%0d cnt=%0d required 0/>0/2/2",
                     pulses, saw_rel, state_o, press_count);
        end
        repeat (10) cycle(1'b0);
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int first = 0;
        while (!(m_state == 2'd1 && m_run == 3) && guard < 20) begin
            cycle(1'b1);
            guard++;
        end
        n_checks++;
        if (guard >= 20 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_mid_reach: got st=%0d after %0d cycles required 1", state_o, guard);
        end
        reset = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if ({reset_sync_n, toggle, press_count, state_o} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got rs=%b tog=%b cnt=%0d st=%0d required all zero",
                     reset_sync_n, toggle, press_count, state_o);
        end
        repeat (2) cycle(1'b1);
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1);
            if (toggle === 1'b1 && first == 0) first = i;
            n_checks++;
            if ({reset_sync_n, toggle, press_count, state_o} !== {m_rs, m_tog, m_cnt, m_state}) begin
                n_fail++;
                $display("FAIL reset_mid_cyc%0d: got %b/%b/%0d/%0d required %b/%b/%0d/%0d", i,
                         reset_sync_n, toggle, press_count, state_o, m_rs, m_tog, m_cnt, m_state);
            end
        end
        n_checks++;
        if (first != SYNC + DB + 1) begin
            n_fail++;
            $display("FAIL reset_mid_repress: got edge %0d required %0d", first, SYNC + DB + 1);
        end
        repeat (10) cycle(1'b0);
    endtask

    task automatic test_wrap();
        int pulses = 0;
        reset = 1'b0;
        m_reset();
        cycle(1'b0);
        reset = 1'b1;
        repeat (SYNC) cycle(1'b0);
        for (int p = 0; p < 256; p++) begin
            for (int k = 0; k < 16; k++) begin
                cycle(k < 8);
                if (toggle === 1'b1) pulses++;
                n_checks++;
                if ({reset_sync_n, toggle, press_count, state_o} !== {m_rs, m_tog, m_cnt, m_state}) begin
                    n_fail++;
                    $display("FAIL wrap_p%0d_k%0d: got %b/%b/%0d/%0d required %b/%b/%0d/%0d", p, k,
                             reset_sync_n, toggle, press_count, state_o, m_rs, m_tog, m_cnt, m_state);
                end
            end
        end
        n_checks++;
        if (pulses != 256 || press_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_end: got pulses=%0d cnt=%0d required 256/0", pulses, press_count);
        end
    endtask

    task automatic test_random();
        logic b = 1'b0;
        int   run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                b = ~b;
                run = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 6);
            end
            run--;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                m_reset();
                #1;
                cycle(b);
                reset = 1'b1;
            end else begin
                cycle(b);
            end
            n_checks++;
            if ({reset_sync_n, toggle, press_count, state_o} !== {m_rs, m_tog, m_cnt, m_state}) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %b/%b/%0d/%0d required %b/%b/%0d/%0d", i,
                         reset_sync_n, toggle, press_count, state_o, m_rs, m_tog, m_cnt, m_state);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_bounce();
        test_clean_press();
        test_release_bounce();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
